// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants for the register file
package regfile_pkg;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_REGS   = 32;
  localparam int RF_ZERO_REG   = 0;
endpackage

// File: rtl/rf_reg32.sv
// rf_reg32: enabled register with synchronous clear (clear wins over enable)
//   i_clk clock, i_clr sync clear, i_en load enable, i_d data in, o_q data out
import regfile_pkg::*;
module rf_reg32 #(
  parameter int WIDTH = RF_DATA_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge i_clk)
    if (i_clr) r_q <= '0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: 2-read 1-write register file, register 0 hardwired to zero
//   clock clock, ctrl_reset sync active-high clear, ctrl_writeEn write enable,
//   ctrl_writeReg write index, ctrl_readRegA/B read indices,
//   data_writeReg write data, data_readRegA/B combinational read data
import regfile_pkg::*;
module reg_file #(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  ctrl_writeEn,
  input  logic                  ctrl_reset,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB
);
  localparam int NUM = 2 ** ADDR_WIDTH;
  logic [NUM-1:1]        w_we;
  logic [DATA_WIDTH-1:0] w_regs [NUM];
  // index 0 has no decoder output and no storage, so writes to it vanish
  assign w_regs[RF_ZERO_REG] = '0;
  for (genvar g = 1; g < NUM; g++) begin : g_reg
    assign w_we[g] = ctrl_writeEn && ctrl_writeReg == ADDR_WIDTH'(g);
    rf_reg32 #(.WIDTH(DATA_WIDTH)) u_reg (
      .i_clk(clock),
      .i_clr(ctrl_reset),
      .i_en (w_we[g]),
      .i_d  (data_writeReg),
      .o_q  (w_regs[g])
    );
  end
  assign data_readRegA = ctrl_readRegA == '0 ? '0 : w_regs[ctrl_readRegA];
  assign data_readRegB = ctrl_readRegB == '0 ? '0 : w_regs[ctrl_readRegB];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plus randomized check of reg_file against an array model
module tb_reg_file;
  logic        clock = 0;
  logic        ctrl_writeEn = 0, ctrl_reset = 0;
  logic [4:0]  ctrl_writeReg = 0, ctrl_readRegA = 0, ctrl_readRegB = 0;
  logic [31:0] data_writeReg = 0, data_readRegA, data_readRegB;
  logic [31:0] m [32];
  int checks = 0, errors = 0;

  reg_file dut (
    .clock(clock), .ctrl_writeEn(ctrl_writeEn), .ctrl_reset(ctrl_reset),
    .ctrl_writeReg(ctrl_writeReg), .ctrl_readRegA(ctrl_readRegA),
    .ctrl_readRegB(ctrl_readRegB), .data_writeReg(data_writeReg),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return a == 0 ? 32'h0 : m[a];
  endfunction

  task automatic cyc(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clock);
    ctrl_reset = rst; ctrl_writeEn = we; ctrl_writeReg = wa; data_writeReg = wd;
    @(posedge clock);
    if (rst) foreach (m[i]) m[i] = 0;
    else if (we && wa != 0) m[wa] = wd;
    #1;
    ctrl_reset = 0; ctrl_writeEn = 0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
    ctrl_readRegA = a; ctrl_readRegB = b;
    #1;
    chk($sformatf("%s A[%0d]", tag, a), data_readRegA, ref_rd(a));
    chk($sformatf("%s B[%0d]", tag, b), data_readRegB, ref_rd(b));
  endtask

  initial begin
    foreach (m[i]) m[i] = 32'hxxxxxxxx;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) rd("reset", 5'(i), 5'(31 - i));
    cyc(0, 1, 0, 32'h0000DEAD);
    rd("zero", 0, 0);
    for (int i = 1; i < 32; i++) begin
      cyc(0, 1, 5'(i), 32'h0000DEAD);
      rd("walk", 5'(i), 5'(i));
      chk($sformatf("walk lit %0d", i), data_readRegA, 32'h0000DEAD);
    end
    cyc(0, 1, 5, 32'h12345678);
    cyc(0, 1, 6, 32'hCAFEF00D);
    rd("iso", 5, 6);
    chk("iso r5 lit", data_readRegA, 32'h12345678);
    chk("iso r6 lit", data_readRegB, 32'hCAFEF00D);
    cyc(0, 0, 5, 32'hFFFFFFFF);
    rd("we0", 5, 6);
    chk("we0 r5 lit", data_readRegA, 32'h12345678);
    cyc(1, 0, 0, 0);
    @(negedge clock);
    ctrl_writeEn = 1; ctrl_writeReg = 7; data_writeReg = 32'hA5A5A5A5; ctrl_readRegA = 7;
    #1;
    chk("collide before", data_readRegA, 32'h0);
    @(posedge clock);
    m[7] = 32'hA5A5A5A5;
    #1;
    ctrl_writeEn = 0;
    chk("collide after", data_readRegA, 32'hA5A5A5A5);
    cyc(1, 1, 9, 32'h1);
    rd("rstprio", 9, 7);
    chk("rstprio lit", data_readRegA, 32'h0);
    cyc(0, 1, 9, 32'h1);
    rd("repop", 9, 9);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) rd("reset2", 5'(i), 5'(i ^ 5'h15));
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 39) == 0, 1'($urandom), 5'($urandom), $urandom);
      rd("rand", 5'($urandom), 5'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
